instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the max cycles waited for a memory response before declaring a fetch error.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset (reset=0 resets).
REQ-004 direinstru  input  32  word address of next instruction, from the program counter.
REQ-005 fetch_en  input  1  permits new fetches to start.
REQ-006 redirect  input  1  branch/jump taken; SHALL flush any in-flight or held fetch.
REQ-007 mem_req  output  1  instruction memory request.
REQ-008 mem_addr  output  32  request address.
REQ-009 mem_gnt  input  1  memory accepted the request this cycle.
REQ-010 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-011 mem_rdata  input  32  instruction word returned.
REQ-012 instr  output  32  fetched instruction to decode.
REQ-013 instr_addr  output  32  address the held instr came from.
REQ-014 instr_valid  output  1  instr/instr_addr valid.
REQ-015 dec_ready  input  1  decoder accepts instr this cycle.
REQ-016 pc_advance  output  1  combinational; SHALL equal instr_valid & dec_ready & ~redirect; PC steps on it.
REQ-017 fetch_err  output  1  sticky memory timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DROP, FULL.
REQ-019 IDLE: if fetch_en=1, fetch_err=0, redirect=0 -> REQ; mem_req<=1, mem_addr<=direinstru; else stay.
REQ-020 REQ: mem_req=1, mem_addr held stable until granted.
REQ-021 REQ, mem_gnt=1, redirect=0 -> WAIT, mem_req<=0.
REQ-022 REQ, mem_gnt=1, redirect=1 -> DROP (accepted request must be drained), mem_req<=0.
REQ-023 REQ, mem_gnt=0, redirect=1 -> IDLE, mem_req<=0 (request withdrawn).
REQ-024 WAIT, mem_rvalid=1, redirect=0 -> FULL; instr<=mem_rdata, instr_addr<=mem_addr, instr_valid<=1.
REQ-025 WAIT, mem_rvalid=1, redirect=1 -> IDLE, data discarded.
REQ-026 WAIT, mem_rvalid=0, redirect=1 -> DROP.
REQ-027 DROP: mem_rvalid=1 -> IDLE, data discarded; instr_valid SHALL remain 0.
REQ-028 Timeout counter SHALL clear on entering WAIT/DROP, increment each cycle there without mem_rvalid; after TIMEOUT such cycles, fetch_err<=1 and state -> IDLE.
REQ-029 fetch_err SHALL stay 1 until reset; while 1 no new mem_req SHALL issue.
REQ-030 FULL: instr, instr_addr, instr_valid SHALL hold stable while dec_ready=0; no new request issued.
REQ-031 FULL, dec_ready=1, redirect=0 -> IDLE, instr_valid<=0, pc_advance=1 in the handshake cycle.
REQ-032 FULL, redirect=1 (any dec_ready) -> IDLE, instr_valid<=0, pc_advance=0; redirect has priority.
REQ-033 fetch_en=0 SHALL only block IDLE->REQ; in-progress fetches complete normally.
REQ-034 Minimum latency: IDLE sampled at edge N, mem_req=1 in cycle N+1; with gnt in N+1 and rvalid in N+2, instr_valid=1 in N+3.
REQ-035 At most one request SHALL be outstanding; mem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-036 Addresses are word addresses; mem_addr SHALL pass direinstru unmodified, no arithmetic.

Reset
REQ-037 reset=0 SHALL immediately force: state IDLE, mem_req=0, mem_addr=0, instr=0, instr_addr=0, instr_valid=0, fetch_err=0, timeout counter=0; pc_advance thus 0.
REQ-038 Reset mid-fetch SHALL abandon the outstanding request; a late mem_rvalid after release SHALL be ignored (state IDLE).
REQ-039 First request after release SHALL issue no earlier than one cycle after the first IDLE edge with fetch_en=1.

Verification
REQ-040 Basic: direinstru=0x00000004, gnt in N+1, rvalid+rdata=0x8C220000 in N+2 -> N+3 instr=0x8C220000, instr_addr=0x4, instr_valid=1; dec_ready=1 -> pc_advance=1 that cycle, instr_valid=0 next.
REQ-041 Backpressure: FULL with dec_ready=0 for 5 cycles -> instr/instr_addr unchanged, mem_req=0 throughout, pc_advance=0.
REQ-042 Redirect in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> instr_valid stays 0, next mem_req carries new direinstru=0x00000040.
REQ-043 Timeout: gnt then no rvalid for 16 cycles -> fetch_err=1, mem_req stays 0 with fetch_en=1 until reset=0.
REQ-044 FULL with redirect=1 and dec_ready=1 same cycle -> pc_advance=0, instr_valid=0 next cycle.
REQ-045 reset=0 asserted mid-WAIT (between edges) -> all outputs 0 without waiting for clk; rvalid after release ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word-addressed request at a time, holds
// the returned instruction for decode, and flags a sticky error on memory timeout.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] direinstru,
  input  logic        fetch_en,
  input  logic        redirect,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  input  logic        dec_ready,
  output logic        pc_advance,
  output logic        fetch_err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    FULL
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_memReq;
  logic [31:0]   r_memAddr;
  logic [31:0]   r_instr;
  logic [31:0]   r_instrAddr;
  logic          r_instrValid;
  logic          r_fetchErr;
  logic [TW-1:0] r_tmoCount;

  logic          w_nextMemReq;
  logic          w_loadAddr;
  logic          w_captureInstr;
  logic          w_nextInstrValid;
  logic          w_setErr;
  logic          w_tmoClear;
  logic          w_tmoInc;
  logic          w_tmoExpired;

  // The counter holds the number of silent cycles already spent waiting, so the
  // cycle that sees it at TIMEOUT-1 without rvalid is the last one tolerated.
  assign w_tmoExpired = (r_tmoCount == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState      = r_state;
    w_nextMemReq     = r_memReq;
    w_loadAddr       = 1'b0;
    w_captureInstr   = 1'b0;
    w_nextInstrValid = r_instrValid;
    w_setErr         = 1'b0;
    w_tmoClear       = 1'b0;
    w_tmoInc         = 1'b0;

    case (r_state)
      IDLE: begin
        w_nextMemReq     = 1'b0;
        w_nextInstrValid = 1'b0;
        if (fetch_en && !r_fetchErr && !redirect) begin
          w_nextState  = REQ;
          w_nextMemReq = 1'b1;
          w_loadAddr   = 1'b1;
        end
      end

      REQ: begin
        w_nextMemReq = 1'b1;
        if (mem_gnt) begin
          // Once granted the response is owed to us, so a redirect must drain it.
          w_nextMemReq = 1'b0;
          w_tmoClear   = 1'b1;
          w_nextState  = redirect ? DROP : WAIT;
        end else if (redirect) begin
          w_nextMemReq = 1'b0;
          w_nextState  = IDLE;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          w_nextState = IDLE;
          if (!redirect) begin
            w_nextState      = FULL;
            w_captureInstr   = 1'b1;
            w_nextInstrValid = 1'b1;
          end
        end else if (w_tmoExpired) begin
          w_setErr    = 1'b1;
          w_nextState = IDLE;
        end else if (redirect) begin
          w_tmoClear  = 1'b1;
          w_nextState = DROP;
        end else begin
          w_tmoInc = 1'b1;
        end
      end

      DROP: begin
        if (mem_rvalid) begin
          w_nextState = IDLE;
        end else if (w_tmoExpired) begin
          w_setErr    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_tmoInc = 1'b1;
        end
      end

      FULL: begin
        if (redirect || dec_ready) begin
          w_nextInstrValid = 1'b0;
          w_nextState      = IDLE;
        end
      end

      default: begin
        w_nextState      = IDLE;
        w_nextMemReq     = 1'b0;
        w_nextInstrValid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_memReq     <= 1'b0;
      r_memAddr    <= 32'd0;
      r_instr      <= 32'd0;
      r_instrAddr  <= 32'd0;
      r_instrValid <= 1'b0;
      r_fetchErr   <= 1'b0;
      r_tmoCount   <= '0;
    end else begin
      r_memReq     <= w_nextMemReq;
      r_instrValid <= w_nextInstrValid;
      if (w_loadAddr) begin
        r_memAddr <= direinstru;
      end
      if (w_captureInstr) begin
        r_instr     <= mem_rdata;
        r_instrAddr <= r_memAddr;
      end
      if (w_setErr) begin
        r_fetchErr <= 1'b1;
      end
      if (w_tmoClear) begin
        r_tmoCount <= '0;
      end else if (w_tmoInc) begin
        r_tmoCount <= r_tmoCount + TW'(1);
      end
    end
  end

  assign mem_req     = r_memReq;
  assign mem_addr    = r_memAddr;
  assign instr       = r_instr;
  assign instr_addr  = r_instrAddr;
  assign instr_valid = r_instrValid;
  assign fetch_err   = r_fetchErr;
  assign pc_advance  = r_instrValid & dec_ready & ~redirect;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected grants/instructions,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_instr_fetch;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] direinstru;
  logic        fetch_en;
  logic        redirect;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        dec_ready;
  logic        pc_advance;
  logic        fetch_err;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } instrExp_t;

  logic [31:0] expAddrQ[$];
  instrExp_t   expInstrQ[$];
  int          vectorCount = 0;
  int          missCount   = 0;
  logic        prevValid   = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .direinstru (direinstru),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_addr (instr_addr),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .pc_advance (pc_advance),
    .fetch_err  (fetch_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic [31:0] dir, input logic gnt,
                               input logic rv, input logic [31:0] rd, input logic dr,
                               input logic rdir);
    fetch_en   = fe;
    direinstru = dir;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rd;
    dec_ready  = dr;
    redirect   = rdir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushInstr(input logic [31:0] data, input logic [31:0] addr);
    instrExp_t e;
    e.data = data;
    e.addr = addr;
    expInstrQ.push_back(e);
  endtask

  // Monitor: every accepted request and every newly presented instruction must match the queue head.
  always @(negedge clk) begin
    instrExp_t e;
    if (reset) begin
      if (mem_req && mem_gnt) begin
        if (expAddrQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL grantAddr: unexpected grant of 0x%08h, required no request", mem_addr);
        end else begin
          checkOutput("grantAddr", mem_addr, expAddrQ.pop_front());
        end
      end
      if (instr_valid && !prevValid) begin
        if (expInstrQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL instrValid: unexpected instr 0x%08h, required instr_valid=0", instr);
        end else begin
          e = expInstrQ.pop_front();
          checkOutput("instrData", instr, e.data);
          checkOutput("instrAddr", instr_addr, e.addr);
        end
      end
    end
    prevValid <= instr_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0);
    reset = 1'b0;
    #12;
    checkOutput("rstMemReq", 32'(mem_req), 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'd0);
    checkOutput("rstValid", 32'(instr_valid), 32'd0);
    checkOutput("rstErr", 32'(fetch_err), 32'd0);
    checkOutput("rstAdvance", 32'(pc_advance), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Basic fetch at minimum latency.
    expAddrQ.push_back(32'h4);
    applyStimulus(1, 32'h4, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h4, 1, 0, 32'h0, 0, 0);
    #1;
    checkOutput("basicReq", 32'(mem_req), 32'd1);
    checkOutput("basicReqAddr", mem_addr, 32'h4);
    tick();
    pushInstr(32'h8C220000, 32'h4);
    applyStimulus(0, 32'h4, 0, 1, 32'h8C220000, 0, 0);
    #1;
    checkOutput("reqDropsAfterGnt", 32'(mem_req), 32'd0);
    tick();
    applyStimulus(0, 32'h4, 0, 0, 32'h0, 1, 0);
    #1;
    checkOutput("basicValid", 32'(instr_valid), 32'd1);
    checkOutput("basicAdvance", 32'(pc_advance), 32'd1);
    tick();
    applyStimulus(0, 32'h4, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("basicValidClears", 32'(instr_valid), 32'd0);

    // Stalled grant keeps address stable, then decoder backpressure holds FULL.
    expAddrQ.push_back(32'h10);
    applyStimulus(1, 32'h10, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(1, 32'h99, 0, 0, 32'h0, 0, 0);
    tick();
    checkOutput("stallReq", 32'(mem_req), 32'd1);
    checkOutput("stallAddrHeld", mem_addr, 32'h10);
    applyStimulus(1, 32'h99, 1, 0, 32'h0, 0, 0);
    tick();
    pushInstr(32'h12345678, 32'h10);
    applyStimulus(1, 32'h99, 0, 1, 32'h12345678, 0, 0);
    tick();
    applyStimulus(1, 32'h99, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bpInstr", instr, 32'h12345678);
      checkOutput("bpInstrAddr", instr_addr, 32'h10);
      checkOutput("bpValid", 32'(instr_valid), 32'd1);
      checkOutput("bpNoReq", 32'(mem_req), 32'd0);
      checkOutput("bpNoAdvance", 32'(pc_advance), 32'd0);
      tick();
    end
    applyStimulus(0, 32'h99, 0, 0, 32'h0, 1, 0);
    #1;
    checkOutput("bpAdvance", 32'(pc_advance), 32'd1);
    tick();

    // Redirect in WAIT: late data is drained, the next request uses the new PC.
    expAddrQ.push_back(32'h20);
    applyStimulus(1, 32'h20, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h20, 1, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 0, 1);
    tick();
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(1, 32'h40, 0, 1, 32'hDEADBEEF, 0, 0);
    tick();
    expAddrQ.push_back(32'h40);
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("dropNoValid", 32'(instr_valid), 32'd0);
    tick();
    applyStimulus(0, 32'h40, 1, 0, 32'h0, 0, 0);
    #1;
    checkOutput("redirReq", 32'(mem_req), 32'd1);
    checkOutput("redirReqAddr", mem_addr, 32'h40);
    tick();
    pushInstr(32'hAABBCCDD, 32'h40);
    applyStimulus(0, 32'h40, 0, 1, 32'hAABBCCDD, 0, 0);
    tick();
    applyStimulus(0, 32'h40, 0, 0, 32'h0, 1, 1);
    #1;
    checkOutput("fullBeforeRedir", 32'(instr_valid), 32'd1);
    checkOutput("redirBlocksAdvance", 32'(pc_advance), 32'd0);
    tick();
    applyStimulus(0, 32'h40, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("redirClearsValid", 32'(instr_valid), 32'd0);

    // Redirect before grant withdraws the request.
    applyStimulus(1, 32'h50, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h50, 0, 0, 32'h0, 0, 1);
    tick();
    applyStimulus(0, 32'h50, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("withdrawReq", 32'(mem_req), 32'd0);
    tick();
    checkOutput("withdrawStaysIdle", 32'(mem_req), 32'd0);

    // Grant together with redirect must still drain the response.
    expAddrQ.push_back(32'h60);
    applyStimulus(1, 32'h60, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h60, 1, 0, 32'h0, 0, 1);
    tick();
    applyStimulus(0, 32'h60, 0, 1, 32'h11111111, 0, 0);
    #1;
    checkOutput("drainNoReq", 32'(mem_req), 32'd0);
    tick();
    applyStimulus(0, 32'h60, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("drainNoValid", 32'(instr_valid), 32'd0);

    // rvalid arriving with redirect in WAIT is discarded.
    expAddrQ.push_back(32'h70);
    applyStimulus(1, 32'h70, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h70, 1, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h70, 0, 1, 32'h22222222, 0, 1);
    tick();
    applyStimulus(0, 32'h70, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("waitRedirDiscard", 32'(instr_valid), 32'd0);
    checkOutput("waitRedirInstrKept", instr, 32'hAABBCCDD);

    // Asynchronous reset in the middle of WAIT.
    expAddrQ.push_back(32'h80);
    applyStimulus(1, 32'h80, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h80, 1, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 32'h80, 0, 0, 32'h0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncRstReq", 32'(mem_req), 32'd0);
    checkOutput("asyncRstAddr", mem_addr, 32'd0);
    checkOutput("asyncRstInstr", instr, 32'd0);
    checkOutput("asyncRstInstrAddr", instr_addr, 32'd0);
    checkOutput("asyncRstValid", 32'(instr_valid), 32'd0);
    checkOutput("asyncRstAdvance", 32'(pc_advance), 32'd0);
    tick();
    reset = 1'b1;
    applyStimulus(0, 32'h0, 0, 1, 32'h33333333, 0, 0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0);
    #1;
    checkOutput("lateRvalidIgnored", 32'(instr_valid), 32'd0);
    checkOutput("lateRvalidNoReq", 32'(mem_req), 32'd0);

    // Memory never answers: sticky error after TIMEOUT silent cycles.
    expAddrQ.push_back(32'h90);
    applyStimulus(1, 32'h90, 0, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(1, 32'h90, 1, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(1, 32'h90, 0, 0, 32'h0, 0, 0);
    repeat (TIMEOUT - 1) tick();
    checkOutput("errNotEarly", 32'(fetch_err), 32'd0);
    tick();
    checkOutput("errSet", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("errNoReq", 32'(mem_req), 32'd0);
      checkOutput("errSticky", 32'(fetch_err), 32'd1);
    end
    reset = 1'b0;
    #1;
    checkOutput("errClearedByRst", 32'(fetch_err), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    checkOutput("addrQueueDrained", 32'(expAddrQ.size()), 32'd0);
    checkOutput("instrQueueDrained", 32'(expInstrQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
